// File: rtl/mem_master_pkg.sv
// Shared types and defaults for the mem_master request initiator.
// The request timeout is built only when MEM_MASTER_TIMEOUT_EN is defined.
package mem_master_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                  err;
        logic [DEF_DATA_W-1:0] rdata;
    } rsp_t;

    // Bits needed to hold a count of max_count (at least one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_master_timer.sv
// Loadable saturating down-counter; last_s flags that the current edge is
// the final one of the loaded interval (count at one or already exhausted).
module mem_master_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last_s
);
    logic [W-1:0] count_r;

    // Count register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign last_s = (count_r <= W'(1));

endmodule

// File: rtl/mem_master.sv
// Single-outstanding memory request initiator with held response port.
// Define MEM_MASTER_TIMEOUT_EN to abandon requests that see no ack.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rd_data
);
    localparam int GAP_W = cnt_width(GAP_CYCLES);

    state_t            state_r, state_s;
    logic              accept_s, ack_take_s, tmo_s, rsp_done_s;
    logic              gap_load_s, gap_dec_s, gap_last_s, tmo_exp_s;
    logic              req_valid_r, rd_wr_r, rsp_valid_r, rsp_err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;

    // Gap timer starts when the request drops, so RSP cycles count toward it.
    mem_master_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (gap_load_s),
        .load_val (GAP_W'(GAP_CYCLES)),
        .dec      (gap_dec_s),
        .last_s   (gap_last_s)
    );

`ifdef MEM_MASTER_TIMEOUT_EN
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    mem_master_timer #(.W(TMO_W)) u_tmo_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (accept_s),
        .load_val (TMO_W'(TIMEOUT_CYCLES)),
        .dec      (state_r == REQ),
        .last_s   (tmo_exp_s)
    );
`else
    assign tmo_exp_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control strobes; ack beats a same-cycle timeout.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        ack_take_s = 1'b0;
        tmo_s      = 1'b0;
        rsp_done_s = 1'b0;
        gap_load_s = 1'b0;
        gap_dec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    state_s  = REQ;
                end else begin
                    state_s  = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    ack_take_s = 1'b1;
                    gap_load_s = 1'b1;
                    state_s    = RSP;
                end else if (tmo_exp_s) begin
                    tmo_s      = 1'b1;
                    gap_load_s = 1'b1;
                    state_s    = RSP;
                end else begin
                    state_s    = REQ;
                end
            end
            RSP: begin
                gap_dec_s = 1'b1;
                if (rsp_ready) begin
                    rsp_done_s = 1'b1;
                    state_s    = gap_last_s ? IDLE : GAP;
                end else begin
                    state_s    = RSP;
                end
            end
            GAP: begin
                gap_dec_s = 1'b1;
                if (gap_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Request and response registers; all held unless a strobe fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_r <= 1'b0;
            rd_wr_r     <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                req_valid_r <= 1'b1;
                rd_wr_r     <= cmd_wr;
                addr_r      <= cmd_addr;
                wdata_r     <= cmd_wdata;
            end else if (ack_take_s || tmo_s) begin
                req_valid_r <= 1'b0;
            end

            if (ack_take_s) begin
                rsp_valid_r <= 1'b1;
                rdata_r     <= rd_wr_r ? {DATA_W{1'b0}} : mem_rd_data;
                rsp_err_r   <= 1'b0;
            end else if (tmo_s) begin
                rsp_valid_r <= 1'b1;
                rdata_r     <= {DATA_W{1'b0}};
                rsp_err_r   <= 1'b1;
            end else if (rsp_done_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign cmd_ready     = (state_r == IDLE);
    assign mem_req_valid = req_valid_r;
    assign mem_rd_wr     = rd_wr_r;
    assign mem_rd_addr   = addr_r;
    assign mem_wr_addr   = addr_r;
    assign mem_wr_data   = wdata_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rdata_r;
    assign rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a word-addressed responder model.
// Timeout expectations follow MEM_MASTER_TIMEOUT_EN.
module tb_mem_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_wr = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = 32'h0;
    logic [DATA_W-1:0] cmd_wdata = 32'h0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_req_valid;
    logic              mem_rd_wr;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rd_data;

    logic [31:0] mem [0:255];
    logic        prev_req_r = 1'b0;
    logic        resp_ack_r = 1'b0;
    logic [31:0] resp_data_r = 32'h0;
    logic        ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    logic [31:0] stray_data = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_rd_wr(mem_rd_wr),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
    );

    assign mem_ack     = resp_ack_r | stray_ack;
    assign mem_rd_data = stray_ack ? stray_data : resp_data_r;

    // Responder: acts on the rising edge of mem_req_valid, acks one cycle later.
    always @(posedge clk) begin
        prev_req_r <= mem_req_valid;
        resp_ack_r <= 1'b0;
        if (mem_req_valid && !prev_req_r && ack_en) begin
            resp_ack_r <= 1'b1;
            if (mem_rd_wr) begin
                mem[mem_wr_addr[7:0]] <= mem_wr_data;
                resp_data_r <= 32'h0;
            end else begin
                resp_data_r <= mem[mem_rd_addr[7:0]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_stray(input logic [31:0] data);
        stray_data = data;
        stray_ack  = 1'b1;
        tick();
        stray_ack  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) mem[8'h30 + i] = 32'hA5A5_0000 + i;

        // Reset state
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_addr", mem_rd_addr, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Read with minimum latency
        check("rd_ready_idle", cmd_ready, 1'b1);
        issue(1'b0, 32'h10, 32'h0);
        check("rd_req_rise", mem_req_valid, 1'b1);
        check("rd_rd_addr", mem_rd_addr, 32'h10);
        check("rd_wr_addr", mem_wr_addr, 32'h10);
        check("rd_rd_wr", mem_rd_wr, 1'b0);
        check("rd_busy", cmd_ready, 1'b0);
        tick();
        check("rd_rsp_early", rsp_valid, 1'b0);
        check("rd_req_held", mem_req_valid, 1'b1);
        tick();
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", rsp_err, 1'b0);
        check("rd_req_drop", mem_req_valid, 1'b0);
        tick();
        check("rd_rsp_taken", rsp_valid, 1'b0);
        check("rd_ready_back", cmd_ready, 1'b1);

        // Write then read back
        issue(1'b1, 32'h20, 32'h12345678);
        check("wr_rd_wr", mem_rd_wr, 1'b1);
        check("wr_wdata", mem_wr_data, 32'h12345678);
        tick(); tick();
        check("wr_rsp_valid", rsp_valid, 1'b1);
        check("wr_rdata_zero", rsp_rdata, 32'h0);
        check("wr_backdoor", mem[8'h20], 32'h12345678);
        tick();
        issue(1'b0, 32'h20, 32'h0);
        tick(); tick();
        check("rb_rdata", rsp_rdata, 32'h12345678);
        tick();

        // Back-to-back reads with cmd_valid held: one accept every 4 cycles
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_addr = 32'h30 + i;
            check("b2b_ready", cmd_ready, 1'b1);
            tick();
            check("b2b_req", mem_req_valid, 1'b1);
            check("b2b_addr", mem_rd_addr, 32'h30 + i);
            tick(); tick();
            check("b2b_rdata", rsp_rdata, 32'hA5A5_0000 + i);
            tick();
            check("b2b_req_low", mem_req_valid, 1'b0);
        end
        cmd_valid = 1'b0;

        // Backpressure, with a stray ack while holding the response
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        tick(); tick();
        check("bp_valid", rsp_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) pulse_stray(32'h55AA55AA);
            else tick();
            check("bp_hold_valid", rsp_valid, 1'b1);
            check("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_ready_low", cmd_ready, 1'b0);
            check("bp_req_low", mem_req_valid, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", rsp_valid, 1'b0);
        check("bp_ready_back", cmd_ready, 1'b1);

        // No acknowledge from the responder
        ack_en = 1'b0;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h40, 32'h0);
        repeat (7) tick();
        check("tmo_not_yet", rsp_valid, 1'b0);
        check("tmo_req_held", mem_req_valid, 1'b1);
        tick();
`ifdef MEM_MASTER_TIMEOUT_EN
        check("tmo_rsp_valid", rsp_valid, 1'b1);
        check("tmo_err", rsp_err, 1'b1);
        check("tmo_rdata", rsp_rdata, 32'h0);
        check("tmo_req_drop", mem_req_valid, 1'b0);
        pulse_stray(32'h0BADF00D);
        check("tmo_late_rdata", rsp_rdata, 32'h0);
        check("tmo_late_err", rsp_err, 1'b1);
`else
        check("tmo_still_req", mem_req_valid, 1'b1);
        check("tmo_no_rsp", rsp_valid, 1'b0);
        check("tmo_busy", cmd_ready, 1'b0);
        check("tmo_err_tied", rsp_err, 1'b0);
        pulse_stray(32'h0BADF00D);
        check("tmo_late_valid", rsp_valid, 1'b1);
        check("tmo_late_rdata", rsp_rdata, 32'h0BADF00D);
`endif
        rsp_ready = 1'b1;
        tick();
        check("tmo_release", rsp_valid, 1'b0);
        check("tmo_ready_back", cmd_ready, 1'b1);
        ack_en = 1'b1;

        // Reset in the middle of a request
        issue(1'b1, 32'h50, 32'hCAFEF00D);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_req_valid, 1'b0);
        check("mid_rst_rd_wr", mem_rd_wr, 1'b0);
        check("mid_rst_addr", mem_wr_addr, 32'h0);
        check("mid_rst_wdata", mem_wr_data, 32'h0);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        tick();
        reset = 1'b1;
        pulse_stray(32'h77777777);
        check("post_rst_no_rsp", rsp_valid, 1'b0);
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_req", mem_req_valid, 1'b0);
        issue(1'b0, 32'h20, 32'h0);
        tick(); tick();
        check("post_rst_rdata", rsp_rdata, 32'h12345678);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
